// File: rtl/fir_filter_if.sv
// Bus bundle for the five-tap FIR filter: an 8-bit input bus shared by
// coefficients and samples, plus the registered result and status flags.
interface fir_filter_if;
  // coef_enable / sample_enable qualify data_in on the rising edge they are
  // sampled. There is no ready: the filter always accepts. out_enable is a
  // one-cycle strobe meaning data_out carries a fresh result.
  logic [7:0]  data_in;
  logic        coef_enable;
  logic        sample_enable;
  logic [15:0] data_out;
  logic        out_enable;
  logic        error;

  modport master (
    output data_in, coef_enable, sample_enable,
    input  data_out, out_enable, error
  );

  modport slave (
    input  data_in, coef_enable, sample_enable,
    output data_out, out_enable, error
  );
endinterface

// File: rtl/fir_filter.sv
// Five-tap direct-form FIR filter with serially loadable coefficients and a
// sticky protocol-error state. The state output exposes the FSM for checkers.
module fir_filter (
  input  logic         clk,
  input  logic         reset,
  fir_filter_if.slave  bus,
  output logic [1:0]   state
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t      st;
  logic [7:0]  coeff [5];
  logic [7:0]  s [5];
  logic [2:0]  count_coeff;
  logic [7:0]  s_next [5];
  logic [18:0] acc;
  logic [15:0] y;

  assign state = st;

  // The result uses the delay line as it will look after this edge's shift.
  always_comb begin
    s_next[0] = bus.data_in;
    for (int i = 1; i < 5; i++) s_next[i] = s[i-1];
    acc = '0;
    for (int i = 0; i < 5; i++) acc = acc + 19'(16'(coeff[i]) * 16'(s_next[i]));
    y = acc[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      count_coeff  <= '0;
      bus.data_out <= '0;
      bus.out_enable <= 1'b0;
      bus.error    <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        coeff[i] <= '0;
        s[i]     <= '0;
      end
    end else begin
      bus.out_enable <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.coef_enable) begin
            coeff[0]    <= bus.data_in;
            count_coeff <= 3'd1;
            st          <= LOAD;
          end
        end
        LOAD: begin
          if (bus.coef_enable && !bus.sample_enable) begin
            for (int i = 1; i < 5; i++)
              if (count_coeff == 3'(i)) coeff[i] <= bus.data_in;
            if (count_coeff == 3'd4) begin
              count_coeff <= '0;
              st          <= RUN;
            end else begin
              count_coeff <= count_coeff + 3'd1;
            end
          end else begin
            st        <= ERROR;
            bus.error <= 1'b1;
          end
        end
        RUN: begin
          // A reload wins over a simultaneous sample and restarts from silence.
          if (bus.coef_enable) begin
            coeff[0]    <= bus.data_in;
            count_coeff <= 3'd1;
            for (int i = 0; i < 5; i++) s[i] <= '0;
            st          <= LOAD;
          end else if (bus.sample_enable) begin
            for (int i = 0; i < 5; i++) s[i] <= s_next[i];
            bus.data_out   <= y;
            bus.out_enable <= 1'b1;
          end
        end
        default: st <= ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_filter.sv
// Randomized scoreboard bench for fir_filter: a transaction-level model
// predicts each strobe's value; a negedge monitor pops and compares.
module tb_fir_filter;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state;

  fir_filter_if bus ();

  fir_filter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [15:0] seen_q[$];

  // Model: 0 idle, 1 loading, 2 running, 3 error
  int         m_phase = 0;
  logic [7:0] m_coef[$];
  logic [7:0] m_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_y();
    int unsigned sum = 0;
    for (int i = 0; i < m_hist.size(); i++)
      sum += int'(m_coef[i]) * int'(m_hist[i]);
    return 16'(sum % 65536);
  endfunction

  task automatic model_step(input logic ce, input logic se, input logic [7:0] d);
    case (m_phase)
      0: if (ce) begin
        m_coef  = {d};
        m_phase = 1;
      end
      1: if (ce && !se) begin
        m_coef.push_back(d);
        if (m_coef.size() == 5) m_phase = 2;
      end else begin
        m_phase = 3;
      end
      2: if (ce) begin
        m_coef  = {d};
        m_hist  = {};
        m_phase = 1;
      end else if (se) begin
        m_hist.push_front(d);
        if (m_hist.size() > 5) void'(m_hist.pop_back());
        exp_q.push_back(model_y());
      end
      default: ;
    endcase
  endtask

  task automatic cycle(input logic ce, input logic se, input logic [7:0] d);
    @(negedge clk);
    bus.coef_enable   = ce;
    bus.sample_enable = se;
    bus.data_in       = d;
    @(posedge clk);
    #1;
    model_step(ce, se, d);
    bus.coef_enable   = 1'b0;
    bus.sample_enable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset             = 1'b1;
    bus.coef_enable   = 1'b0;
    bus.sample_enable = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_phase = 0;
    m_coef  = {};
    m_hist  = {};
    check("pending_at_reset", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load(input logic [7:0] c [5]);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, c[i]);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  // Monitor: every strobe must match the oldest prediction; error must
  // track the model's protocol state.
  always @(negedge clk) begin
    check("error_flag", bus.error, (m_phase == 3) ? 1 : 0);
    if (bus.out_enable) begin
      seen_q.push_back(bus.data_out);
      if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
      else check("data_out", bus.data_out, exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] imp_exp [6];
    logic [7:0]  c [5];
    imp_exp = '{16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd0};

    reset = 1'b1;
    bus.coef_enable = 1'b0;
    bus.sample_enable = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_data_out", bus.data_out, 0);
    check("reset_out_enable", bus.out_enable, 0);
    check("reset_error", bus.error, 0);

    // Samples in IDLE are ignored
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    drain();

    // Impulse response
    seen_q = {};
    load('{8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
    cycle(1'b0, 1'b1, 8'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'd0);
    drain();
    check("impulse_count", seen_q.size(), 6);
    for (int i = 0; i < 6 && i < seen_q.size(); i++) check("impulse_value", seen_q[i], imp_exp[i]);

    // Aborted load
    do_reset();
    cycle(1'b1, 1'b0, 8'd4);
    cycle(1'b1, 1'b0, 8'd5);
    cycle(1'b1, 1'b0, 8'd6);
    cycle(1'b0, 1'b0, 8'd7);
    check("abort_error_set", bus.error, 1);
    cycle(1'b1, 1'b0, 8'd8);
    check("abort_error_sticky", bus.error, 1);
    cycle(1'b0, 1'b1, 8'd3);
    drain();
    do_reset();
    check("abort_error_cleared", bus.error, 0);

    // Overflow wrap
    seen_q = {};
    load('{8'd255, 8'd255, 8'd255, 8'd255, 8'd255});
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'd255);
    drain();
    check("wrap_count", seen_q.size(), 5);
    if (seen_q.size() > 0) check("wrap_value", seen_q[seen_q.size()-1], 62981);

    // Reload in RUN, first reload beat carrying a sample that must be ignored
    do_reset();
    load('{8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'($urandom_range(1, 255)));
    drain();
    seen_q = {};
    cycle(1'b1, 1'b1, 8'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 8'd3);
    cycle(1'b0, 1'b1, 8'd9);
    drain();
    check("reload_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("reload_first", seen_q[0], 3);
      check("reload_second", seen_q[1], 9);
    end

    // Sample during LOAD
    do_reset();
    cycle(1'b1, 1'b0, 8'd2);
    cycle(1'b1, 1'b0, 8'd3);
    cycle(1'b1, 1'b1, 8'd5);
    check("load_sample_error", bus.error, 1);

    // Randomized run with gaps, reloads and resets
    do_reset();
    for (int i = 0; i < 5; i++) c[i] = 8'($urandom_range(0, 255));
    load(c);
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        for (int i = 0; i < 5; i++) c[i] = 8'($urandom_range(0, 255));
        load(c);
      end else if (r == 1) begin
        drain();
        do_reset();
        load(c);
      end else if (r < 8) begin
        cycle(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      end else begin
        cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)));
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
